// File: rtl/cache_tag_engine_if.sv
// ---------------------------------------------------------------------------
// cache_tag_engine_if
//   Request/response bundle between a requester and cache_tag_engine.
//
//   master : the requester. It drives req_valid/req_addr/req_write and both
//            policy bits, and it observes req_ready, the resp_* lookup
//            result and the statistics counters.
//   slave  : the tag engine. It uses the opposite directions.
//
//   TAG_W is derived from the address width and the set/line geometry. It
//   has to match the TAG_W that the engine computes from the same numbers.
// ---------------------------------------------------------------------------
interface cache_tag_engine_if #(
    parameter int ADDR_W      = 48,
    parameter int BLOCK_BYTES = 64,
    parameter int NUM_SETS    = 64,
    parameter int CNT_W       = 32
);
    localparam int TAG_W = ADDR_W - $clog2(BLOCK_BYTES) - $clog2(NUM_SETS);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic              replace_policy;
    logic              write_policy;

    logic              resp_valid;
    logic              resp_hit;
    logic              resp_writeback;
    logic [TAG_W-1:0]  resp_evict_tag;

    logic [CNT_W-1:0]  num_reads;
    logic [CNT_W-1:0]  num_writes;
    logic [CNT_W-1:0]  num_hits;
    logic [CNT_W-1:0]  num_misses;
    logic [CNT_W-1:0]  num_writebacks;

    modport master (
        output req_valid, req_addr, req_write, replace_policy, write_policy,
        input  req_ready, resp_valid, resp_hit, resp_writeback, resp_evict_tag,
        input  num_reads, num_writes, num_hits, num_misses, num_writebacks
    );

    modport slave (
        input  req_valid, req_addr, req_write, replace_policy, write_policy,
        output req_ready, resp_valid, resp_hit, resp_writeback, resp_evict_tag,
        output num_reads, num_writes, num_hits, num_misses, num_writebacks
    );
endinterface

// File: rtl/cache_tag_engine.sv
// ---------------------------------------------------------------------------
// cache_tag_engine
//   Tag/state engine for a set-associative cache. It holds valid, dirty, tag
//   and age for every line. Each accepted request runs through the states
//   IDLE -> LOOKUP -> UPDATE -> RESP. The engine reports hit or miss and any
//   dirty eviction, and it keeps saturating statistics counters.
//
//   Ports
//     clk    : clock; all state changes on the rising edge
//     reset  : synchronous, active-high reset
//     bus    : cache_tag_engine_if.slave
//              request  : req_valid/req_ready handshake, req_addr, req_write,
//                         replace_policy (0 FIFO, 1 LRU),
//                         write_policy (0 WT/no-allocate, 1 WB/allocate)
//              response : resp_valid pulse, resp_hit, resp_writeback,
//                         resp_evict_tag
//              stats    : num_reads/writes/hits/misses/writebacks
//
//   Tag, dirty and age live in a set-wide RAM with a registered read. The RAM
//   is read on the acceptance edge, so the set is ready during LOOKUP. The
//   RAM is written back at the end of UPDATE. Valid bits are kept in
//   flip-flops so that reset can clear every line at once. The RAM contents
//   of an invalid way are never used, so they do not need clearing.
// ---------------------------------------------------------------------------
module cache_tag_engine #(
    parameter int ADDR_W      = 48,
    parameter int BLOCK_BYTES = 64,
    parameter int NUM_SETS    = 64,
    parameter int ASSOC       = 8,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    cache_tag_engine_if.slave bus
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int AGE_W = $clog2(ASSOC);
    localparam logic [AGE_W-1:0] AGE_OLDEST = AGE_W'(ASSOC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             dirty;
        logic [AGE_W-1:0] age;
    } line_t;

    typedef line_t [ASSOC-1:0] set_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   req_ready, resp_valid, accept, lookup_en, update_en;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             write_q, write_d;
    logic             lru_q, lru_d;
    logic             wpol_q, wpol_d;

    set_t mem [NUM_SETS];
    set_t rd_set_q;

    logic [NUM_SETS-1:0][ASSOC-1:0] valid_q, valid_d;
    logic [ASSOC-1:0]               set_valid;
    logic [ASSOC-1:0]               match;

    logic             lk_hit;
    logic [AGE_W-1:0] lk_hit_way, lk_vic_way;
    logic             hit_q, hit_d;
    logic [AGE_W-1:0] hit_way_q, hit_way_d;
    logic [AGE_W-1:0] vic_way_q, vic_way_d;

    line_t            vic_line;
    logic             vic_valid;
    logic [AGE_W-1:0] hit_age;
    logic             allocate;
    logic             upd_wb;
    set_t             new_set;
    logic [ASSOC-1:0] new_valid;

    logic [CNT_W-1:0] num_reads_q, num_reads_d;
    logic [CNT_W-1:0] num_writes_q, num_writes_d;
    logic [CNT_W-1:0] num_hits_q, num_hits_d;
    logic [CNT_W-1:0] num_misses_q, num_misses_d;
    logic [CNT_W-1:0] num_writebacks_q, num_writebacks_d;

    logic             resp_hit_q, resp_hit_d;
    logic             resp_wb_q, resp_wb_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign req_idx = bus.req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag = bus.req_addr[ADDR_W-1:OFF_W+IDX_W];

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOOKUP;
            LOOKUP:  state_d = UPDATE;
            UPDATE:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is also gated by reset. Holding reset therefore refuses requests
    // even though the state register already reads IDLE.
    always_comb begin
        req_ready  = (state_q == IDLE) && !reset;
        accept     = req_ready && bus.req_valid;
        lookup_en  = (state_q == LOOKUP);
        update_en  = (state_q == UPDATE) && !reset;
        resp_valid = (state_q == RESP);
    end

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_comb begin
        idx_d   = idx_q;
        tag_d   = tag_q;
        write_d = write_q;
        lru_d   = lru_q;
        wpol_d  = wpol_q;
        if (accept) begin
            idx_d   = req_idx;
            tag_d   = req_tag;
            write_d = bus.req_write;
            lru_d   = bus.replace_policy;
            wpol_d  = bus.write_policy;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            tag_q   <= '0;
            write_q <= 1'b0;
            lru_q   <= 1'b0;
            wpol_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            write_q <= write_d;
            lru_q   <= lru_d;
            wpol_q  <= wpol_d;
        end
    end

    // ------------------------------------------------------------------
    // Set RAM. A read happens only on acceptance and a write only in
    // UPDATE, so the two ports never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (update_en) mem[idx_q] <= new_set;
        if (accept)    rd_set_q   <= mem[req_idx];
    end

    always_comb begin
        valid_d = valid_q;
        if (update_en) valid_d[idx_q] = new_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // ------------------------------------------------------------------
    // LOOKUP: parallel tag compare and victim choice
    // ------------------------------------------------------------------
    assign set_valid = valid_q[idx_q];

    for (genvar gi = 0; gi < ASSOC; gi++) begin : g_way
        assign match[gi] = set_valid[gi] && (rd_set_q[gi].tag == tag_q);
    end

    always_comb begin
        // Only a single matching way counts as a hit.
        lk_hit     = $onehot(match);
        lk_hit_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (match[w]) lk_hit_way = AGE_W'(w);
        end
        // Prefer the lowest invalid way. When the set is full, take the
        // oldest way instead.
        lk_vic_way = '0;
        if (&set_valid) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (rd_set_q[w].age == AGE_OLDEST) lk_vic_way = AGE_W'(w);
            end
        end else begin
            for (int w = ASSOC - 1; w >= 0; w--) begin
                if (!set_valid[w]) lk_vic_way = AGE_W'(w);
            end
        end
    end

    always_comb begin
        hit_d     = hit_q;
        hit_way_d = hit_way_q;
        vic_way_d = vic_way_q;
        if (lookup_en) begin
            hit_d     = lk_hit;
            hit_way_d = lk_hit_way;
            vic_way_d = lk_vic_way;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            vic_way_q <= '0;
        end else begin
            hit_q     <= hit_d;
            hit_way_q <= hit_way_d;
            vic_way_q <= vic_way_d;
        end
    end

    // ------------------------------------------------------------------
    // UPDATE: new set contents (age, dirty, fill)
    // ------------------------------------------------------------------
    always_comb begin
        vic_line  = rd_set_q[vic_way_q];
        vic_valid = set_valid[vic_way_q];
        hit_age   = rd_set_q[hit_way_q].age;
        allocate  = !hit_q && (!write_q || wpol_q);
        upd_wb    = allocate && vic_valid && vic_line.dirty;
        new_set   = rd_set_q;
        new_valid = set_valid;
        if (hit_q) begin
            // Under FIFO, ages record only the fill order, so a hit leaves
            // them untouched.
            if (lru_q) begin
                for (int w = 0; w < ASSOC; w++) begin
                    if (set_valid[w] && (rd_set_q[w].age < hit_age))
                        new_set[w].age = rd_set_q[w].age + AGE_W'(1);
                end
                new_set[hit_way_q].age = '0;
            end
            if (write_q && wpol_q) new_set[hit_way_q].dirty = 1'b1;
        end else if (allocate) begin
            // Filling an invalid way ages every valid line. Replacing a
            // valid line ages only the lines younger than the one leaving.
            for (int w = 0; w < ASSOC; w++) begin
                if (set_valid[w] && (!vic_valid || (rd_set_q[w].age < vic_line.age)))
                    new_set[w].age = rd_set_q[w].age + AGE_W'(1);
            end
            new_set[vic_way_q].tag   = tag_q;
            // A write can only allocate under write-back, so write_q alone
            // selects the dirty state of the new line.
            new_set[vic_way_q].dirty = write_q;
            new_set[vic_way_q].age   = '0;
            new_valid[vic_way_q]     = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Statistics and held response
    // ------------------------------------------------------------------
    always_comb begin
        num_reads_d      = num_reads_q;
        num_writes_d     = num_writes_q;
        num_hits_d       = num_hits_q;
        num_misses_d     = num_misses_q;
        num_writebacks_d = num_writebacks_q;
        resp_hit_d       = resp_hit_q;
        resp_wb_d        = resp_wb_q;
        resp_tag_d       = resp_tag_q;
        if (update_en) begin
            if (write_q) num_writes_d = sat_inc(num_writes_q);
            else         num_reads_d  = sat_inc(num_reads_q);
            if (hit_q)   num_hits_d   = sat_inc(num_hits_q);
            else         num_misses_d = sat_inc(num_misses_q);
            if (upd_wb)  num_writebacks_d = sat_inc(num_writebacks_q);
            resp_hit_d = hit_q;
            resp_wb_d  = upd_wb;
            resp_tag_d = upd_wb ? vic_line.tag : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_reads_q      <= '0;
            num_writes_q     <= '0;
            num_hits_q       <= '0;
            num_misses_q     <= '0;
            num_writebacks_q <= '0;
            resp_hit_q       <= 1'b0;
            resp_wb_q        <= 1'b0;
            resp_tag_q       <= '0;
        end else begin
            num_reads_q      <= num_reads_d;
            num_writes_q     <= num_writes_d;
            num_hits_q       <= num_hits_d;
            num_misses_q     <= num_misses_d;
            num_writebacks_q <= num_writebacks_d;
            resp_hit_q       <= resp_hit_d;
            resp_wb_q        <= resp_wb_d;
            resp_tag_q       <= resp_tag_d;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.resp_valid     = resp_valid;
    assign bus.resp_hit       = resp_hit_q;
    assign bus.resp_writeback = resp_wb_q;
    assign bus.resp_evict_tag = resp_tag_q;
    assign bus.num_reads      = num_reads_q;
    assign bus.num_writes     = num_writes_q;
    assign bus.num_hits       = num_hits_q;
    assign bus.num_misses     = num_misses_q;
    assign bus.num_writebacks = num_writebacks_q;

endmodule

// File: tb/tb_cache_tag_engine.sv
// ---------------------------------------------------------------------------
// tb_cache_tag_engine
//   Directed bench for cache_tag_engine. It uses the default geometry (48-bit
//   addresses, 64 sets, 8 ways) and narrow 4-bit counters so that saturation
//   can be reached. Expected responses are queued when a request is driven
//   and compared when resp_valid appears.
// ---------------------------------------------------------------------------
module tb_cache_tag_engine;
    localparam int ADDR_W      = 48;
    localparam int BLOCK_BYTES = 64;
    localparam int NUM_SETS    = 64;
    localparam int ASSOC       = 8;
    localparam int CNT_W       = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_tag_engine_if #(
        .ADDR_W(ADDR_W), .BLOCK_BYTES(BLOCK_BYTES), .NUM_SETS(NUM_SETS), .CNT_W(CNT_W)
    ) bus ();

    cache_tag_engine #(
        .ADDR_W(ADDR_W), .BLOCK_BYTES(BLOCK_BYTES), .NUM_SETS(NUM_SETS),
        .ASSOC(ASSOC), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int     hit;
        int     wb;
        longint tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] set0(input int t);
        return ADDR_W'(t) << 12;
    endfunction

    task automatic chk_cnt(input int r, input int w, input int h, input int m, input int wb);
        chk("num_reads",      64'(bus.num_reads),      64'(r));
        chk("num_writes",     64'(bus.num_writes),     64'(w));
        chk("num_hits",       64'(bus.num_hits),       64'(h));
        chk("num_misses",     64'(bus.num_misses),     64'(m));
        chk("num_writebacks", 64'(bus.num_writebacks), 64'(wb));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = '0;
        repeat (cycles) begin
            @(negedge clk);
            chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
        end
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(bus.req_ready),      64'd1);
        chk("rst_resp_valid",    64'(bus.resp_valid),     64'd0);
        chk("rst_resp_hit",      64'(bus.resp_hit),       64'd0);
        chk("rst_resp_wb",       64'(bus.resp_writeback), 64'd0);
        chk("rst_resp_tag",      64'(bus.resp_evict_tag), 64'd0);
        chk_cnt(0, 0, 0, 0, 0);
    endtask

    task automatic do_req(input logic [ADDR_W-1:0] addr, input int wr, input int rp, input int wp,
                          input int eh, input int ew, input longint et);
        exp_t e;
        exp_t got;
        int   waited;
        e.hit = eh;
        e.wb  = ew;
        e.tag = et;
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid      = 1'b1;
        bus.req_addr       = addr;
        bus.req_write      = wr[0];
        bus.replace_policy = rp[0];
        bus.write_policy   = wp[0];
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) chk("accept_timeout", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble the inputs after acceptance. The request in flight must
        // ignore them.
        bus.req_valid      = 1'b0;
        bus.req_addr       = ADDR_W'({$urandom(), $urandom()});
        bus.req_write      = 1'($urandom_range(0, 1));
        bus.replace_policy = 1'($urandom_range(0, 1));
        bus.write_policy   = 1'($urandom_range(0, 1));
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.resp_valid !== 1'b1 && waited < 10);
        got = sb.pop_front();
        n_txn++;
        $display("txn %0d addr=0x%0h wr=%0d rp=%0d wp=%0d -> hit=%0d wb=%0d evict_tag=0x%0h",
                 n_txn, addr, wr, rp, wp, bus.resp_hit, bus.resp_writeback, bus.resp_evict_tag);
        chk("resp_latency", 64'(waited),             64'd3);
        chk("resp_hit",     64'(bus.resp_hit),       64'(got.hit));
        chk("resp_wb",      64'(bus.resp_writeback), 64'(got.wb));
        chk("resp_tag",     64'(bus.resp_evict_tag), 64'(got.tag));
        @(negedge clk);
        chk("resp_pulse",    64'(bus.resp_valid), 64'd0);
        chk("resp_hit_hold", 64'(bus.resp_hit),   64'(got.hit));
    endtask

    initial begin
        int seen;
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.req_write      = 1'b0;
        bus.replace_policy = 1'b0;
        bus.write_policy   = 1'b0;

        // Basic read miss/hit, plus line-offset and set-index boundaries
        do_reset(3);
        do_req(48'h1000, 0, 0, 0, 0, 0, 0);
        do_req(48'h1000, 0, 0, 0, 1, 0, 0);
        chk_cnt(2, 0, 1, 1, 0);
        do_req(48'h1040, 0, 0, 0, 0, 0, 0);   // same tag, set 1
        do_req(48'h103F, 0, 0, 0, 1, 0, 0);   // last byte of the first line
        chk_cnt(4, 0, 2, 2, 0);

        // FIFO: nine tags into set 0, then T0 has been evicted
        do_reset(2);
        for (int t = 0; t <= 8; t++) do_req(set0(t), 0, 0, 0, 0, 0, 0);
        do_req(set0(0), 0, 0, 0, 0, 0, 0);
        chk_cnt(10, 0, 0, 10, 0);

        // LRU: the hit on T0 protects it, so T1 is evicted instead
        do_reset(2);
        for (int t = 0; t <= 7; t++) do_req(set0(t), 0, 1, 0, 0, 0, 0);
        do_req(set0(0), 0, 1, 0, 1, 0, 0);
        do_req(set0(8), 0, 1, 0, 0, 0, 0);
        do_req(set0(0), 0, 1, 0, 1, 0, 0);
        chk_cnt(11, 0, 2, 9, 0);

        // Same sequence under FIFO: T0 is evicted anyway
        do_reset(2);
        for (int t = 0; t <= 7; t++) do_req(set0(t), 0, 0, 0, 0, 0, 0);
        do_req(set0(0), 0, 0, 0, 1, 0, 0);
        do_req(set0(8), 0, 0, 0, 0, 0, 0);
        do_req(set0(0), 0, 0, 0, 0, 0, 0);
        chk_cnt(11, 0, 1, 10, 0);

        // Write-back: a write miss allocates a dirty line, later evicted
        do_reset(2);
        do_req(48'h0, 1, 0, 1, 0, 0, 0);
        for (int t = 1; t <= 7; t++) do_req(set0(t), 0, 0, 1, 0, 0, 0);
        do_req(set0(8), 0, 0, 1, 0, 1, 0);
        chk_cnt(8, 1, 0, 9, 1);

        // Write-back FIFO: a write hit dirties the oldest line
        do_reset(2);
        for (int t = 'h30; t <= 'h37; t++) do_req(set0(t), 0, 0, 1, 0, 0, 0);
        do_req(set0('h30), 1, 0, 1, 1, 0, 0);
        do_req(set0('h38), 0, 0, 1, 0, 1, 'h30);
        chk_cnt(9, 1, 1, 9, 1);

        // Write-back LRU: evict a dirty line, then a write hit makes 0x10 MRU
        do_reset(2);
        do_req(set0(5), 1, 1, 1, 0, 0, 0);
        for (int t = 'h10; t <= 'h16; t++) do_req(set0(t), 0, 1, 1, 0, 0, 0);
        do_req(set0('h17), 0, 1, 1, 0, 1, 5);
        do_req(set0('h10), 1, 1, 1, 1, 0, 0);
        do_req(set0('h18), 0, 1, 1, 0, 0, 0);   // 0x11 is LRU and clean
        do_req(set0('h10), 0, 1, 1, 1, 0, 0);
        chk_cnt(10, 2, 2, 10, 1);

        // Write-through: no allocate on a write miss, no dirty on a write hit
        do_reset(2);
        do_req(set0(2), 1, 0, 0, 0, 0, 0);
        do_req(set0(2), 0, 0, 0, 0, 0, 0);
        chk_cnt(1, 1, 0, 2, 0);
        do_req(set0(2), 1, 0, 0, 1, 0, 0);
        for (int t = 'h20; t <= 'h26; t++) do_req(set0(t), 0, 0, 0, 0, 0, 0);
        do_req(set0('h27), 0, 0, 0, 0, 0, 0);   // evicts tag 2, which is clean
        chk_cnt(9, 2, 1, 10, 0);

        // Counter saturation at 2^CNT_W-1
        do_reset(2);
        for (int i = 0; i < 17; i++) do_req(48'h7000, 0, 0, 0, (i != 0) ? 1 : 0, 0, 0);
        chk_cnt(15, 0, 15, 1, 0);

        // Reset during LOOKUP drops the request and clears the cached line
        do_reset(2);
        do_req(48'h4000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("abort_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid      = 1'b1;
        bus.req_addr       = 48'h4000;
        bus.req_write      = 1'b0;
        bus.replace_policy = 1'b0;
        bus.write_policy   = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) seen++;
        end
        chk("abort_no_resp", 64'(seen), 64'd0);
        chk_cnt(0, 0, 0, 0, 0);
        do_req(48'h4000, 0, 0, 0, 0, 0, 0);
        chk_cnt(1, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_tag_engine.md
CACHE_TAG_ENGINE -- requirements
Module: cache_tag_engine

Interface
REQ-001 Parameter ADDR_W, default 48, request address width in bits.
REQ-002 Parameter BLOCK_BYTES, default 64, line size; power of two, >=4.
REQ-003 Parameter NUM_SETS, default 64, set count; power of two, >=2.
REQ-004 Parameter ASSOC, default 8, ways per set; power of two, 2..16.
REQ-005 Parameter CNT_W, default 32, statistics counter width.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  block can accept a request; high only in IDLE.
REQ-010 req_addr  in  ADDR_W  byte address of the access.
REQ-011 req_write  in  1  1 = write, 0 = read.
REQ-012 replace_policy  in  1  0 = FIFO, 1 = LRU; sampled at acceptance.
REQ-013 write_policy  in  1  0 = write-through/no-allocate, 1 = write-back/allocate; sampled at acceptance.
REQ-014 resp_valid  out  1  one-cycle pulse: lookup result available.
REQ-015 resp_hit  out  1  access hit; valid with resp_valid.
REQ-016 resp_writeback  out  1  a dirty line was evicted; valid with resp_valid.
REQ-017 resp_evict_tag  out  TAG_W  tag of the evicted dirty line; 0 when resp_writeback=0.
REQ-018 num_reads, num_writes, num_hits, num_misses, num_writebacks  out  CNT_W each  saturating statistics counters.

Function
REQ-019 OFF_W=log2(BLOCK_BYTES), IDX_W=log2(NUM_SETS), TAG_W=ADDR_W-OFF_W-IDX_W; index=req_addr[OFF_W+IDX_W-1:OFF_W]; tag=req_addr[ADDR_W-1:OFF_W+IDX_W].
REQ-020 Each line holds valid, dirty, TAG_W tag and a log2(ASSOC)-bit age (0 = newest/MRU); ages within a valid set form a permutation of 0..ASSOC-1.
REQ-021 FSM states IDLE, LOOKUP, UPDATE, RESP; IDLE->LOOKUP on req_valid&&req_ready, LOOKUP->UPDATE, UPDATE->RESP, RESP->IDLE, unconditionally.
REQ-022 On acceptance, address, write flag and both policy bits are registered; later input changes have no effect on that request.
REQ-023 LOOKUP compares the tag against all valid ways of the set in parallel; hit = exactly one valid way matches.
REQ-024 resp_valid is high for exactly the one cycle in RESP, 3 cycles after the acceptance edge; next request is accepted no earlier than the cycle after RESP.
REQ-025 Victim on allocation: lowest-numbered invalid way, else the way with age ASSOC-1.
REQ-026 Fill: victim way gets valid=1, new tag, age 0; every other valid way with age lower than the victim's old age (all valid ways, if the victim was invalid) increments by 1.
REQ-027 LRU hit: hit way age->0; ways with age lower than its old age increment by 1; FIFO hit: ages unchanged.
REQ-028 Read miss always allocates; write miss allocates only when write_policy=1.
REQ-029 write_policy=1: write hit sets dirty; write-miss fill sets dirty=1; read-miss fill sets dirty=0.
REQ-030 write_policy=0: dirty never set; write hit leaves dirty unchanged.
REQ-031 Eviction of a valid dirty victim: resp_writeback=1, resp_evict_tag=victim tag, num_writebacks+1.
REQ-032 Per accepted request exactly one of num_reads/num_writes and one of num_hits/num_misses increments, in UPDATE; each counter holds at 2^CNT_W-1.
REQ-033 resp_hit, resp_writeback, resp_evict_tag hold their values until the next RESP; they are 0 after reset.

Reset
REQ-034 reset in any state: FSM->IDLE, all valid/dirty bits and ages cleared, all counters and resp_* outputs 0, req_ready=1 on the following cycle.
REQ-035 A request in flight when reset asserts is dropped: no resp_valid, no counter change.
REQ-036 reset held for several cycles keeps req_ready=0 and ignores req_valid.

Verification
REQ-037 Reset, read 0x1000 twice (FIFO) -> first resp_hit=0, second resp_hit=1; num_reads=2, num_hits=1, num_misses=1.
REQ-038 Defaults, FIFO: read tags T0..T8 (9 addresses, stride 0x1000, same set 0), then T0 -> T0 misses (evicted oldest); num_misses=10.
REQ-039 LRU: fill set 0 with T0..T7, read T0, read T8, read T0 -> last read hits (T1 evicted); FIFO same sequence -> last read misses.
REQ-040 write_policy=1: write 0x0, then read 8 new tags in set 0 (FIFO) -> 8th read response resp_writeback=1, resp_evict_tag=0, num_writebacks=1.
REQ-041 write_policy=0: write 0x2000 (miss), read 0x2000 -> both miss, resp_writeback never set, num_writes=1.
REQ-042 Assert reset during LOOKUP -> no resp_valid, all counters 0, following read of the same address misses.
